// File: rtl/ex3_pkg.sv
// Shared Excess-3 decode constants and the stream FSM state type.
package ex3_pkg;
    localparam logic [3:0] EX3_OFFSET  = 4'd3;
    localparam logic [3:0] EX3_MIN     = 4'h3;
    localparam logic [3:0] EX3_MAX     = 4'hC;
    localparam logic [3:0] BCD_INVALID = 4'hF;

    typedef enum logic {
        COLLECT = 1'b0,
        EMIT    = 1'b1
    } state_e;
endpackage

// File: rtl/ex3_digit_dec.sv
// Combinational Excess-3 digit decoder: zero latency, no flow control.
// Out-of-range codes decode to BCD_INVALID with invalid_o raised.
module ex3_digit_dec
    import ex3_pkg::*;
(
    input  logic [3:0] code_i,
    output logic [3:0] dig_o,
    output logic       invalid_o
);
    always_comb begin
        invalid_o = (code_i < EX3_MIN) || (code_i > EX3_MAX);
        dig_o     = invalid_o ? BCD_INVALID : (code_i - EX3_OFFSET);
    end
endmodule

// File: rtl/ex3_to_bcd_stream.sv
// Excess-3 beat stream to packed-BCD words; word valid the cycle after its last beat,
// input stalls while a word waits in EMIT. EX3_ERR_CNT_EN adds a saturating err_cnt.
module ex3_to_bcd_stream
    import ex3_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [3:0]                   in_code,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [4*DIGITS-1:0]          out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]  out_ndig,
    output logic                         out_err
`ifdef EX3_ERR_CNT_EN
    ,
    output logic [7:0]                   err_cnt
`endif
);
    localparam int BW = 4 * DIGITS;
    localparam int NW = $clog2(DIGITS + 1);

    state_e          state_q, state_d;
    logic [BW-1:0]   bcd_q, bcd_d;
    logic [NW-1:0]   ndig_q, ndig_d;
    logic            err_q, err_d;

    logic [3:0]      dig;
    logic            invalid;
    logic            accept;
    logic [NW-1:0]   ndig_inc;
    logic [BW-1:0]   dig_ext;

    ex3_digit_dec u_dec (
        .code_i    (in_code),
        .dig_o     (dig),
        .invalid_o (invalid)
    );

    assign in_ready  = (state_q == COLLECT);
    assign out_valid = (state_q == EMIT);
    assign accept    = in_valid && in_ready;
    assign ndig_inc  = ndig_q + NW'(1);

    always_comb begin
        dig_ext      = '0;
        dig_ext[3:0] = dig;
    end

    always_comb begin
        state_d = state_q;
        bcd_d   = bcd_q;
        ndig_d  = ndig_q;
        err_d   = err_q;
        case (state_q)
            COLLECT: begin
                if (accept) begin
                    bcd_d  = (bcd_q << 4) | dig_ext;
                    ndig_d = ndig_inc;
                    err_d  = err_q | invalid;
                    // A full word terminates even without in_last.
                    if (in_last || (ndig_inc == NW'(DIGITS))) begin
                        state_d = EMIT;
                    end
                end
            end
            EMIT: begin
                if (out_ready) begin
                    state_d = COLLECT;
                    bcd_d   = '0;
                    ndig_d  = '0;
                    err_d   = 1'b0;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= COLLECT;
            bcd_q   <= '0;
            ndig_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bcd_q   <= bcd_d;
            ndig_q  <= ndig_d;
            err_q   <= err_d;
        end
    end

    assign out_bcd  = bcd_q;
    assign out_ndig = ndig_q;
    assign out_err  = err_q;

`ifdef EX3_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (accept && invalid && (err_cnt_q != 8'hFF)) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_cnt_q <= 8'd0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif
endmodule

// File: tb/tb_ex3_to_bcd_stream.sv
// Scoreboard bench for ex3_to_bcd_stream: driver queues expected words, monitor checks handshakes.
module tb_ex3_to_bcd_stream;
    localparam int DIGITS = 4;

    typedef struct {
        logic [15:0] bcd;
        logic [2:0]  ndig;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_code;
    logic        in_last;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_bcd;
    logic [2:0]  out_ndig;
    logic        out_err;
`ifdef EX3_ERR_CNT_EN
    logic [7:0]  err_cnt;
`endif

    ex3_to_bcd_stream #(.DIGITS(DIGITS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_bcd   (out_bcd),
        .out_ndig  (out_ndig),
        .out_err   (out_err)
`ifdef EX3_ERR_CNT_EN
        ,
        .err_cnt   (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   failures = 0;
    exp_t sb[$];
    int   model_errs = 0;
    int   words_seen = 0;
    bit   rdy_rand = 1'b0;
    bit   rdy_force = 1'b1;

    function automatic logic [3:0] ref_dig(input logic [3:0] c);
        if (c >= 4'd3 && c <= 4'd12) return c - 4'd3;
        return 4'hF;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
        end
    end

    // Monitor: scoreboard pops on every completed output handshake.
    bit          stall = 1'b0;
    bit          prev_hs = 1'b0;
    logic [15:0] h_bcd;
    logic [2:0]  h_ndig;
    logic        h_err;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                stall   = 1'b0;
                prev_hs = 1'b0;
            end else begin
                if (prev_hs) chk("valid_one_cycle", 32'(out_valid), 32'd0);
                prev_hs = 1'b0;
                if (stall && out_valid) begin
                    chk("stall_bcd", 32'(out_bcd), 32'(h_bcd));
                    chk("stall_ndig", 32'(out_ndig), 32'(h_ndig));
                    chk("stall_err", 32'(out_err), 32'(h_err));
                    chk("stall_in_ready", 32'(in_ready), 32'd0);
                end
                stall = 1'b0;
                if (out_valid) begin
                    if (out_ready) begin
                        if (sb.size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_word: got %0h expected none", out_bcd);
                        end else begin
                            exp_t e;
                            e = sb.pop_front();
                            chk("word_bcd", 32'(out_bcd), 32'(e.bcd));
                            chk("word_ndig", 32'(out_ndig), 32'(e.ndig));
                            chk("word_err", 32'(out_err), 32'(e.err));
`ifdef EX3_ERR_CNT_EN
                            chk("word_err_cnt", 32'(err_cnt), 32'(model_errs));
`endif
                        end
                        words_seen++;
                        prev_hs = 1'b1;
                    end else begin
                        stall  = 1'b1;
                        h_bcd  = out_bcd;
                        h_ndig = out_ndig;
                        h_err  = out_err;
                    end
                end
            end
        end
    end

    task automatic send_word(input logic [3:0] c[8], input int n, input bit use_last,
                             input bit use_exp, input logic [15:0] exp_bcd, input bit gaps);
        exp_t        e;
        logic [31:0] acc;
        bit          errf;
        bit          complete;
        int          budget;
        acc  = 0;
        errf = 1'b0;
        for (int i = 0; i < n; i++) begin
            acc = acc * 16 + 32'(ref_dig(c[i]));
            if (ref_dig(c[i]) == 4'hF) errf = 1'b1;
        end
        e.bcd    = use_exp ? exp_bcd : acc[15:0];
        e.ndig   = 3'(n);
        e.err    = errf;
        complete = use_last || (n == DIGITS);
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_code  = c[i];
            in_last  = use_last && (i == n - 1);
            if (complete && i == n - 1) sb.push_back(e);
            budget = 0;
            while (!in_ready && budget < 200) begin
                @(posedge clk);
                #1;
                budget++;
            end
            if (!in_ready) begin
                chk("in_ready_timeout", 32'(in_ready), 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
            if (ref_dig(c[i]) == 4'hF && model_errs < 255) model_errs++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while (sb.size() > 0 && budget < 2000) begin
            @(posedge clk);
            #1;
            budget++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [3:0] cw[8];
    logic [3:0] cw2[8];
    int         base;
    int         n;

    initial begin
        rst      = 1'b1;
        in_valid = 1'b1;
        in_code  = 4'h4;
        in_last  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_bcd", 32'(out_bcd), 32'd0);
        chk("rst_out_ndig", 32'(out_ndig), 32'd0);
        chk("rst_out_err", 32'(out_err), 32'd0);
`ifdef EX3_ERR_CNT_EN
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
`endif
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(posedge clk);
        #1;
        chk("post_rst_ndig", 32'(out_ndig), 32'd0);

        cw = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 4, 1'b1, 1'b1, 16'h1234, 1'b0);
        cw = '{4'hC, 4'h3, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 2, 1'b1, 1'b1, 16'h0090, 1'b0);
        cw = '{4'h4, 4'hE, 4'h5, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 3, 1'b1, 1'b1, 16'h01F2, 1'b0);
        drain();
`ifdef EX3_ERR_CNT_EN
        chk("dir_err_cnt", 32'(err_cnt), 32'd1);
`endif

        // Consumer stalls while the next word is already being offered.
        rdy_force = 1'b0;
        cw  = '{4'h8, 4'h9, 4'hA, 4'hB, 4'h0, 4'h0, 4'h0, 4'h0};
        cw2 = '{4'h9, 4'hA, 4'hB, 4'hC, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 4, 1'b0, 1'b1, 16'h5678, 1'b0);
        fork
            send_word(cw2, 4, 1'b1, 1'b1, 16'h6789, 1'b0);
            begin
                repeat (5) @(posedge clk);
                #1;
                chk("stall_hold_valid", 32'(out_valid), 32'd1);
                rdy_force = 1'b1;
            end
        join
        drain();

        cw = '{4'h4, 4'h5, 4'h6, 4'h7, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 2, 1'b0, 1'b0, 16'h0, 1'b0);
        #2;
        rst        = 1'b1;
        model_errs = 0;
        in_valid   = 1'b1;
        #1;
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        chk("midrst_out_ndig", 32'(out_ndig), 32'd0);
        chk("midrst_out_bcd", 32'(out_bcd), 32'd0);
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        cw = '{4'h8, 4'h9, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        send_word(cw, 2, 1'b1, 1'b1, 16'h0056, 1'b0);
        drain();

        rdy_rand = 1'b1;
        for (int w = 0; w < 60; w++) begin
            n = $urandom_range(1, DIGITS);
            for (int i = 0; i < 8; i++) begin
                if ($urandom_range(0, 9) < 7) cw[i] = 4'($urandom_range(3, 12));
                else cw[i] = 4'($urandom_range(0, 15));
            end
            send_word(cw, n, (n < DIGITS) ? 1'b1 : 1'($urandom_range(0, 1)), 1'b0, 16'h0, 1'b1);
        end
        drain();
        rdy_rand  = 1'b0;
        rdy_force = 1'b1;

        base = words_seen;
        cw = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0};
        for (int w = 0; w < 75; w++) begin
            send_word(cw, 4, 1'($urandom_range(0, 1)), 1'b1, 16'hFFFF, 1'b0);
        end
        drain();
        chk("sat_word_count", 32'(words_seen - base), 32'd75);
`ifdef EX3_ERR_CNT_EN
        chk("sat_err_cnt", 32'(err_cnt), 32'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
